// File: rtl/rename_regfile_pkg.sv
// rename_regfile_pkg: shared widths, types and constants for the rename register file.
package rename_regfile_pkg;
    localparam int REG_POS_W = 5;
    localparam int ROB_ID_W  = 5;
    localparam int DATA_W    = 32;
    typedef logic [REG_POS_W-1:0] REG_POS_TYPE;
    typedef logic [ROB_ID_W-1:0]  ROB_ID_TYPE;
    typedef logic [DATA_W-1:0]    DATA_TYPE;
    localparam REG_POS_TYPE ZERO_REG  = '0;
    localparam ROB_ID_TYPE  ZERO_ROB  = '0;
    localparam DATA_TYPE    ZERO_WORD = '0;
    localparam logic        TRUE      = 1'b1;
    localparam logic        FALSE     = 1'b0;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one source-operand read with same-cycle commit forwarding.
module regfile_read_port
    import rename_regfile_pkg::*;
#(
    parameter int REG_NUM       = 32,
    parameter int REG_POS_WIDTH = 5,
    parameter int ROB_ID_WIDTH  = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic [REG_POS_WIDTH-1:0] rs,
    input  logic [ROB_ID_WIDTH-1:0]  tags [REG_NUM],
    input  logic [DATA_WIDTH-1:0]    words [REG_NUM],
    input  logic                     commit_flag,
    input  logic [REG_POS_WIDTH-1:0] rd_from_rob,
    input  logic [ROB_ID_WIDTH-1:0]  Q_from_rob,
    input  logic [DATA_WIDTH-1:0]    V_from_rob,
    output logic [ROB_ID_WIDTH-1:0]  q,
    output logic [DATA_WIDTH-1:0]    v
);
    logic zero;
    logic fwd;
    always_comb begin
        zero = rs == '0;
        fwd  = commit_flag && rd_from_rob == rs && tags[rs] == Q_from_rob;
        q    = (zero || fwd) ? '0 : tags[rs];
        v    = zero ? '0 : fwd ? V_from_rob : words[rs];
    end
endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: architectural registers plus ROB rename tags, with commit, rename and rollback.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int REG_NUM       = 32,
    parameter int REG_POS_WIDTH = 5,
    parameter int ROB_ID_WIDTH  = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic [REG_POS_WIDTH-1:0] rs1_from_dsp,
    input  logic [REG_POS_WIDTH-1:0] rs2_from_dsp,
    output logic [ROB_ID_WIDTH-1:0]  Q1_to_dsp,
    output logic [DATA_WIDTH-1:0]    V1_to_dsp,
    output logic [ROB_ID_WIDTH-1:0]  Q2_to_dsp,
    output logic [DATA_WIDTH-1:0]    V2_to_dsp,
    input  logic                     ena_from_dsp,
    input  logic [REG_POS_WIDTH-1:0] rd_from_dsp,
    input  logic [ROB_ID_WIDTH-1:0]  rob_id_from_dsp,
    input  logic                     commit_flag,
    input  logic [REG_POS_WIDTH-1:0] rd_from_rob,
    input  logic [ROB_ID_WIDTH-1:0]  Q_from_rob,
    input  logic [DATA_WIDTH-1:0]    V_from_rob,
    input  logic                     rollback_flag
);
    logic [ROB_ID_WIDTH-1:0] tag_q  [REG_NUM];
    logic [ROB_ID_WIDTH-1:0] tag_d  [REG_NUM];
    logic [DATA_WIDTH-1:0]   data_q [REG_NUM];
    logic [DATA_WIDTH-1:0]   data_d [REG_NUM];
    logic [REG_NUM-1:0]      cmt_hit;
    logic [REG_NUM-1:0]      ren_hit;
    // x0 never matches a hit, so its tag and data stay at their reset value of zero
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            cmt_hit[i] = i != 0 && commit_flag && rd_from_rob == REG_POS_WIDTH'(i);
            ren_hit[i] = i != 0 && ena_from_dsp && !rollback_flag && rd_from_dsp == REG_POS_WIDTH'(i);
            data_d[i]  = cmt_hit[i] ? V_from_rob : data_q[i];
            tag_d[i]   = rollback_flag ? '0 :
                         ren_hit[i] ? rob_id_from_dsp :
                         (cmt_hit[i] && tag_q[i] == Q_from_rob) ? '0 : tag_q[i];
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_NUM; i++) begin
            if (rst) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end else if (rdy) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end
    regfile_read_port #(
        .REG_NUM(REG_NUM), .REG_POS_WIDTH(REG_POS_WIDTH),
        .ROB_ID_WIDTH(ROB_ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) u_rp1 (
        .rs(rs1_from_dsp), .tags(tag_q), .words(data_q),
        .commit_flag(commit_flag), .rd_from_rob(rd_from_rob),
        .Q_from_rob(Q_from_rob), .V_from_rob(V_from_rob),
        .q(Q1_to_dsp), .v(V1_to_dsp)
    );
    regfile_read_port #(
        .REG_NUM(REG_NUM), .REG_POS_WIDTH(REG_POS_WIDTH),
        .ROB_ID_WIDTH(ROB_ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) u_rp2 (
        .rs(rs2_from_dsp), .tags(tag_q), .words(data_q),
        .commit_flag(commit_flag), .rd_from_rob(rd_from_rob),
        .Q_from_rob(Q_from_rob), .V_from_rob(V_from_rob),
        .q(Q2_to_dsp), .v(V2_to_dsp)
    );
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed scoreboard bench for rename_regfile read, rename, commit and rollback.
module tb_rename_regfile;
    import rename_regfile_pkg::*;
    logic        clk = 1'b0;
    logic        rst, rdy;
    REG_POS_TYPE rs1_from_dsp, rs2_from_dsp, rd_from_dsp, rd_from_rob;
    ROB_ID_TYPE  Q1_to_dsp, Q2_to_dsp, rob_id_from_dsp, Q_from_rob;
    DATA_TYPE    V1_to_dsp, V2_to_dsp, V_from_rob;
    logic        ena_from_dsp, commit_flag, rollback_flag;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        string      name;
        ROB_ID_TYPE q1;
        DATA_TYPE   v1;
        ROB_ID_TYPE q2;
        DATA_TYPE   v2;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rename_regfile dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rs1_from_dsp(rs1_from_dsp), .rs2_from_dsp(rs2_from_dsp),
        .Q1_to_dsp(Q1_to_dsp), .V1_to_dsp(V1_to_dsp),
        .Q2_to_dsp(Q2_to_dsp), .V2_to_dsp(V2_to_dsp),
        .ena_from_dsp(ena_from_dsp), .rd_from_dsp(rd_from_dsp), .rob_id_from_dsp(rob_id_from_dsp),
        .commit_flag(commit_flag), .rd_from_rob(rd_from_rob),
        .Q_from_rob(Q_from_rob), .V_from_rob(V_from_rob),
        .rollback_flag(rollback_flag)
    );

    task automatic chk(input string name, input string fld, input DATA_TYPE got, input DATA_TYPE exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", name, fld, got, exp);
        end
    endtask

    // drive read indices, push the expected operands, then pop and compare once settled
    task automatic rd_chk(input string name, input REG_POS_TYPE a, input REG_POS_TYPE b,
                          input ROB_ID_TYPE q1, input DATA_TYPE v1,
                          input ROB_ID_TYPE q2, input DATA_TYPE v2);
        exp_t e;
        rs1_from_dsp = a;
        rs2_from_dsp = b;
        sb.push_back('{name, q1, v1, q2, v2});
        #1;
        e = sb.pop_front();
        chk(e.name, "Q1", DATA_TYPE'(Q1_to_dsp), DATA_TYPE'(e.q1));
        chk(e.name, "V1", V1_to_dsp, e.v1);
        chk(e.name, "Q2", DATA_TYPE'(Q2_to_dsp), DATA_TYPE'(e.q2));
        chk(e.name, "V2", V2_to_dsp, e.v2);
    endtask

    task automatic ren(input REG_POS_TYPE rd, input ROB_ID_TYPE id);
        ena_from_dsp    = 1'b1;
        rd_from_dsp     = rd;
        rob_id_from_dsp = id;
    endtask

    task automatic cmt(input REG_POS_TYPE rd, input ROB_ID_TYPE q, input DATA_TYPE v);
        commit_flag = 1'b1;
        rd_from_rob = rd;
        Q_from_rob  = q;
        V_from_rob  = v;
    endtask

    task automatic cyc();
        @(negedge clk);
        ena_from_dsp  = 1'b0;
        commit_flag   = 1'b0;
        rollback_flag = 1'b0;
        rd_from_dsp   = '0;
        rob_id_from_dsp = '0;
        rd_from_rob   = '0;
        Q_from_rob    = '0;
        V_from_rob    = '0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        rs1_from_dsp = '0;
        rs2_from_dsp = '0;
        cyc();
        cyc();
        rst = 1'b0;
        rd_chk("reset", 5, 31, 0, 0, 0, 0);

        ren(3, 4);
        cyc();
        rd_chk("rename_x3", 3, 0, 4, 0, 0, 0);
        cmt(3, 4, 32'hDEADBEEF);
        rd_chk("commit_fwd", 3, 3, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        cyc();
        rd_chk("commit_done", 3, 0, 0, 32'hDEADBEEF, 0, 0);

        ren(7, 2);
        cyc();
        ren(7, 9);
        cyc();
        cmt(7, 2, 32'h11);
        rd_chk("stale_nofwd", 7, 3, 9, 0, 0, 32'hDEADBEEF);
        cyc();
        rd_chk("stale_commit", 7, 0, 9, 32'h11, 0, 0);

        ren(4, 6);
        cyc();
        rd_chk("x4_tag6", 4, 7, 6, 0, 9, 32'h11);
        cmt(4, 6, 32'h55);
        ren(4, 10);
        rd_chk("sim_fwd", 4, 0, 0, 32'h55, 0, 0);
        cyc();
        rd_chk("sim_ren_cmt", 4, 0, 10, 32'h55, 0, 0);

        ren(1, 3);
        cyc();
        ren(2, 5);
        cyc();
        rd_chk("pre_rollback", 1, 2, 3, 0, 5, 0);
        rollback_flag = 1'b1;
        cmt(1, 3, 32'h80);
        ren(9, 7);
        cyc();
        rd_chk("rollback_x1x2", 1, 2, 0, 32'h80, 0, 0);
        rd_chk("rollback_x9x7", 9, 7, 0, 0, 0, 32'h11);
        rd_chk("rollback_x4x3", 4, 3, 0, 32'h55, 0, 32'hDEADBEEF);

        ren(0, 5);
        cmt(0, 5, 32'h1);
        rd_chk("x0_same", 0, 0, 0, 0, 0, 0);
        cyc();
        rd_chk("x0_after", 0, 0, 0, 0, 0, 0);

        rdy = 1'b0;
        ren(8, 3);
        cmt(3, 0, 32'h99);
        cyc();
        rdy = 1'b1;
        rd_chk("rdy_freeze", 8, 3, 0, 0, 0, 32'hDEADBEEF);

        ren(5, 12);
        cyc();
        rd_chk("x5_tag12", 5, 0, 12, 0, 0, 0);
        rst = 1'b1;
        cmt(4, 0, 32'h77);
        ren(6, 1);
        cyc();
        rst = 1'b0;
        rd_chk("midrst_a", 5, 4, 0, 0, 0, 0);
        rd_chk("midrst_b", 3, 6, 0, 0, 0, 0);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rename_regfile.md
# rename_regfile

Architectural register file with Tomasulo rename tags for the out-of-order RV32I core. It holds 32 data words plus one ROB tag per register. The dispatcher reads source operands and tags from it and records the destination tag of each newly allocated instruction. The reorder buffer writes committed results into it and, on a branch mispredict, triggers a rollback that clears every tag.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hard-wired to zero.
- REG_POS_WIDTH, 5, register index width.
- ROB_ID_WIDTH, 5, ROB tag width. Tag 0 means "no pending producer"; ROB entry k has tag k+1.
- DATA_WIDTH, 32, data word width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global ready; when low, state is frozen.
- rs1_from_dsp  in  REG_POS_WIDTH  source register 1 index.
- rs2_from_dsp  in  REG_POS_WIDTH  source register 2 index.
- Q1_to_dsp  out  ROB_ID_WIDTH  tag of rs1 (0 = value valid).
- V1_to_dsp  out  DATA_WIDTH  value of rs1.
- Q2_to_dsp  out  ROB_ID_WIDTH  tag of rs2.
- V2_to_dsp  out  DATA_WIDTH  value of rs2.
- ena_from_dsp  in  1  rename request.
- rd_from_dsp  in  REG_POS_WIDTH  destination register of the new instruction.
- rob_id_from_dsp  in  ROB_ID_WIDTH  ROB tag allocated to the new instruction.
- commit_flag  in  1  the ROB commits this cycle.
- rd_from_rob  in  REG_POS_WIDTH  committed destination register.
- Q_from_rob  in  ROB_ID_WIDTH  tag of the committing entry.
- V_from_rob  in  DATA_WIDTH  committed value.
- rollback_flag  in  1  mispredict flush.

## Operation
- State: `data[REG_NUM]` and `tag[REG_NUM]`.
- Reset (rst high at a clock edge): every `data` and every `tag` is cleared to 0. Reads then return Q=0 and V=0.
- While rdy is low: no state changes. Reads stay live.
- Commit, when commit_flag is high and rd_from_rob ≠ 0:
  - `data[rd] <= V_from_rob`.
  - `tag[rd] <= 0`, but only if `tag[rd] == Q_from_rob` and no rename of the same rd is applied this cycle.
  - A stale tag (the register was renamed again by a younger instruction) is left unchanged.
- Rename, when ena_from_dsp is high, rd_from_dsp ≠ 0 and rollback_flag is low: `tag[rd] <= rob_id_from_dsp`.
- Rollback, when rollback_flag is high:
  - All tags are cleared to 0.
  - A commit in the same cycle still writes its data; the mispredicting jalr/jal writes rd.
  - A rename in the same cycle is dropped.
- Priority per register: rst > rollback tag-clear > rename > commit tag-clear. The data write from a commit always happens unless rst or rdy is low.
- x0: writes are ignored; reads of index 0 return Q=0, V=0.

Read port (combinational, per source; identical logic for port 1 and port 2):
- If `rs == 0`: Q=0, V=0.
- Else if `commit_flag && rd_from_rob == rs && tag[rs] == Q_from_rob`: Q=0, V=V_from_rob. This is same-cycle commit forwarding.
- Else: Q=tag[rs], V=data[rs].
- A rename in the same cycle never affects the read ports. An instruction's own destination must not alias its sources (e.g. `add x1,x1,x2` reads the old x1 mapping).

## Timing
- Reads: zero latency, combinational from rs inputs and the commit inputs.
- Commit, rename and rollback take effect at the clock edge. They are visible on the read ports the following cycle (commit is visible the same cycle through forwarding).
- Commit and rename to the same rd in the same cycle:
  - data takes the committed value;
  - tag takes the new rob_id;
  - the next-cycle read returns the new tag.
- Commit and rollback in the same cycle: data is written and all tags read 0 the next cycle.
- rst asserted mid-operation clears everything at that edge, regardless of the other inputs.
- Tag wrap-around is handled by the ROB. This block only performs equality compares on the full ROB_ID_WIDTH.

## Structure
- Shared defines package: REG_POS_TYPE, ROB_ID_TYPE, DATA_TYPE, ZERO_ROB, ZERO_REG, ZERO_WORD, TRUE/FALSE.
- One sub-module, `regfile_read_port`, implements the forwarding mux. It takes the rs index, the tag/data array outputs and the commit inputs, and is instantiated once for each source.
- Expected size: about 150–200 lines.

## Test plan
- **Reset:** after rst, read rs1=5, rs2=31 → Q1=Q2=0, V1=V2=0.
- **Rename then commit:**
  - Rename x3 → tag 4. The next cycle reads Q=4.
  - Commit rd=3, Q=4, V=0xDEADBEEF. In that same cycle the read gives Q=0, V=0xDEADBEEF. The next cycle reads Q=0, V=0xDEADBEEF.
- **Stale commit:**
  - Rename x7 → 2, then rename x7 → 9.
  - Commit rd=7, Q=2, V=0x11 → x7 reads Q=9, V=0x11.
- **Simultaneous rename and commit:**
  - x4 holds tag 6. In one cycle, commit rd=4, Q=6, V=0x55 and rename x4 → 10.
  - The next cycle reads Q=10, V=0x55.
- **Rollback:**
  - Tags x1=3 and x2=5 are pending.
  - In one cycle, assert rollback with commit rd=1, Q=3, V=0x80, plus a rename of x9 → 7.
  - The next cycle: x1 reads Q=0, V=0x80; x2 reads Q=0; x9 reads Q=0.
- **x0 and rdy:**
  - Rename x0 → 5 and commit rd=0, V=1 → x0 reads 0/0.
  - With rdy=0, rename x8 → 3 → x8 stays Q=0.
